// File: rtl/video_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : video_stream_gen                                                 |
// | Brief   : Framed vsync/href/gray test-pattern source with blanking.        |
// |           Optional impulse noise when SALT_PEPPER_EN is defined.           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module video_stream_gen #(
   parameter int IMG_H_DISP    = 640,
   parameter int IMG_V_DISP    = 480,
   parameter int H_BLANK       = 160,
   parameter int V_BLANK_LINES = 45,
   parameter int NOISE_PERIOD  = 97
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        post_img_vsync,
   output logic        post_img_href,
   output logic [7:0]  post_img_gray,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);
   localparam int H_TOTAL = IMG_H_DISP + H_BLANK;
   localparam int V_MAX   = (IMG_V_DISP > V_BLANK_LINES) ? IMG_V_DISP : V_BLANK_LINES;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_MAX + 1);

   localparam logic [HW-1:0] c_H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] c_A_LAST  = HW'(IMG_H_DISP - 1);
   localparam logic [VW-1:0] c_V_LAST  = VW'(IMG_V_DISP - 1);
   localparam logic [VW-1:0] c_VB_LAST = VW'(V_BLANK_LINES - 1);
   localparam logic [7:0]    c_SEED    = 8'hA5;

   typedef enum logic [1:0] {S_IDLE, S_V_BLANK, S_H_ACTIVE, S_H_BLANK} state_t;

   state_t          r_state;
   logic [HW-1:0]   r_hcnt;
   logic [VW-1:0]   r_vcnt;
   logic [1:0]      r_pat;
   logic [7:0]      r_lfsr;
   logic            r_vsync;
   logic            r_href;
   logic [7:0]      r_gray;
   logic            r_done;
   logic [15:0]     r_fcnt;

   logic            w_h_last, w_a_last, w_vb_end, w_line_nx, w_px_nx, w_pix_go;
   logic [HW-1:0]   w_nx;
   logic [VW-1:0]   w_ny;
   logic [7:0]      w_x8, w_y8;
   logic [1:0]      w_pat;
   logic [7:0]      w_lfsr, w_lfsr_nx, w_pattern, w_gray;

   generate
      if (NOISE_PERIOD < 1 || H_BLANK < 1 || V_BLANK_LINES < 1) begin : g_bad_params
         $error("video_stream_gen: NOISE_PERIOD, H_BLANK and V_BLANK_LINES must be >= 1");
      end
   endgenerate

   // Coordinates and pattern of the pixel that the next edge will present.
   always_comb begin
      w_h_last  = (r_hcnt == c_H_LAST);
      w_a_last  = (r_hcnt == c_A_LAST);
      w_vb_end  = (r_state == S_V_BLANK) && w_h_last && (r_vcnt == c_VB_LAST);
      w_line_nx = (r_state == S_H_BLANK) && w_h_last && (r_vcnt < c_V_LAST);
      w_px_nx   = (r_state == S_H_ACTIVE) && !w_a_last;
      w_pix_go  = w_vb_end || w_line_nx || w_px_nx;
      w_nx      = w_px_nx ? r_hcnt + 1'b1 : '0;
      w_ny      = w_vb_end ? '0 : (w_line_nx ? r_vcnt + 1'b1 : r_vcnt);
      w_x8      = 8'(w_nx);
      w_y8      = 8'(w_ny);
      w_pat     = w_vb_end ? pattern_sel : r_pat;
      w_lfsr    = w_vb_end ? c_SEED : r_lfsr;
      w_lfsr_nx = {w_lfsr[6:0], w_lfsr[7] ^ w_lfsr[5] ^ w_lfsr[4] ^ w_lfsr[3]};
      case (w_pat)
         2'd0:    w_pattern = w_x8;
         2'd1:    w_pattern = w_y8;
         2'd2:    w_pattern = (w_x8[3] ^ w_y8[3]) ? 8'hFF : 8'h00;
         default: w_pattern = w_lfsr;
      endcase
   end

`ifdef SALT_PEPPER_EN
   localparam int PW = $clog2(NOISE_PERIOD + 1);
   localparam logic [PW-1:0] c_N_LAST = PW'(NOISE_PERIOD - 1);

   logic [PW-1:0] r_pix, w_pix;
   logic          r_imp, w_imp, w_hit;

   always_comb begin
      w_pix  = w_vb_end ? '0 : r_pix;
      w_imp  = w_vb_end ? 1'b1 : r_imp;
      w_hit  = (w_pix == c_N_LAST);
      w_gray = w_hit ? {8{w_imp}} : w_pattern;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pix <= '0;
         r_imp <= 1'b1;
      end else if (w_pix_go) begin
         r_pix <= w_hit ? '0 : w_pix + 1'b1;
         r_imp <= w_hit ? ~w_imp : w_imp;
      end
   end
`else
   assign w_gray = w_pattern;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_hcnt  <= '0;
         r_vcnt  <= '0;
         r_pat   <= 2'd0;
         r_lfsr  <= 8'h00;
         r_vsync <= 1'b0;
         r_href  <= 1'b0;
         r_gray  <= 8'h00;
         r_done  <= 1'b0;
         r_fcnt  <= 16'd0;
      end else begin
         r_done <= 1'b0;
         r_href <= w_pix_go;
         r_gray <= w_pix_go ? w_gray : 8'h00;
         if (w_pix_go) begin
            r_lfsr <= w_lfsr_nx;
         end
         case (r_state)
            S_IDLE: begin
               r_hcnt <= '0;
               r_vcnt <= '0;
               if (enable) begin
                  r_state <= S_V_BLANK;
               end
            end
            S_V_BLANK: begin
               r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
               if (w_vb_end) begin
                  r_vcnt  <= '0;
                  r_pat   <= pattern_sel;
                  r_vsync <= 1'b1;
                  r_state <= S_H_ACTIVE;
               end else if (w_h_last) begin
                  r_vcnt <= r_vcnt + 1'b1;
               end
            end
            S_H_ACTIVE: begin
               r_hcnt <= r_hcnt + 1'b1;
               if (w_a_last) begin
                  r_state <= S_H_BLANK;
               end
            end
            S_H_BLANK: begin
               if (!w_h_last) begin
                  r_hcnt <= r_hcnt + 1'b1;
               end else if (w_line_nx) begin
                  r_hcnt  <= '0;
                  r_vcnt  <= r_vcnt + 1'b1;
                  r_state <= S_H_ACTIVE;
               end else begin
                  // End of frame: enable only decides what follows, never truncates.
                  r_hcnt  <= '0;
                  r_vcnt  <= '0;
                  r_vsync <= 1'b0;
                  r_done  <= 1'b1;
                  r_fcnt  <= r_fcnt + 16'd1;
                  r_state <= enable ? S_V_BLANK : S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign post_img_vsync = r_vsync;
   assign post_img_href  = r_href;
   assign post_img_gray  = r_gray;
   assign frame_done     = r_done;
   assign frame_cnt      = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_video_stream_gen                                              |
// | Brief   : Directed, table-driven bench for video_stream_gen (8/4/4/2).     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_video_stream_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable;
   logic [1:0]  pattern_sel;
   logic        vsync, href, fdone;
   logic [7:0]  gray;
   logic [15:0] fcnt;

   logic        en2;
   logic [1:0]  pat2;
   logic        vsync2, href2, fdone2;
   logic [7:0]  gray2;
   logic [15:0] fcnt2;

   video_stream_gen #(.IMG_H_DISP(8), .IMG_V_DISP(4), .H_BLANK(4),
                      .V_BLANK_LINES(2), .NOISE_PERIOD(5)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
      .post_img_vsync(vsync), .post_img_href(href), .post_img_gray(gray),
      .frame_done(fdone), .frame_cnt(fcnt));

   video_stream_gen #(.IMG_H_DISP(16), .IMG_V_DISP(16), .H_BLANK(4),
                      .V_BLANK_LINES(2), .NOISE_PERIOD(1000)) dut_chk (
      .clk(clk), .rst_n(rst_n), .enable(en2), .pattern_sel(pat2),
      .post_img_vsync(vsync2), .post_img_href(href2), .post_img_gray(gray2),
      .frame_done(fdone2), .frame_cnt(fcnt2));

   typedef struct {
      int         frm;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   localparam int NV = 29;
   vec_t       vt [0:NV-1];
   logic [7:0] fpix [0:7][0:31];
   logic [7:0] cpix [0:255];
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_vs(output int n);
      n = 0;
      while (vsync !== 1'b1 && n < 500) begin
         step();
         if (vsync !== 1'b1) n++;
      end
   endtask

   // Records one frame from its first active cycle until vsync falls.
   task automatic cap(input int fi, input int sw_at, input logic [1:0] sw_pat,
                      input logic sw_en, output int nv, output int np,
                      output int hv_err, output logic fd, output logic [15:0] fc);
      nv = 0; np = 0; hv_err = 0;
      while (vsync === 1'b1 && nv < 2000) begin
         if (href !== (((nv % 12) < 8) ? 1'b1 : 1'b0)) hv_err++;
         if (href === 1'b1) begin
            if (np < 32) fpix[fi][np] = gray;
            np++;
         end else if (gray !== 8'h00) begin
            hv_err++;
         end
         if (nv == sw_at) begin
            pattern_sel = sw_pat;
            enable      = sw_en;
         end
         nv++;
         step();
      end
      fd = fdone;
      fc = fcnt;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nv, np, hv, np2, c, bad;
      logic fd;
      logic [15:0] fc;

      vt[0]  = '{0, 0, 8'h00};  vt[1]  = '{0, 7, 8'h07};  vt[2]  = '{0, 8, 8'h00};
      vt[3]  = '{0, 13, 8'h05}; vt[4]  = '{0, 31, 8'h07};
      vt[5]  = '{1, 0, 8'h00};  vt[6]  = '{1, 8, 8'h01};  vt[7]  = '{1, 20, 8'h02};
      vt[8]  = '{1, 31, 8'h03};
      vt[9]  = '{2, 0, 8'hA5};  vt[10] = '{2, 1, 8'h4A};  vt[11] = '{2, 2, 8'h95};
      vt[12] = '{2, 3, 8'h2A};  vt[13] = '{2, 5, 8'hA9};  vt[14] = '{2, 6, 8'h53};
      vt[15] = '{2, 7, 8'hA7};  vt[16] = '{2, 8, 8'h4E};
      vt[17] = '{3, 0, 8'hA5};  vt[18] = '{3, 1, 8'h4A};  vt[19] = '{3, 8, 8'h4E};
      vt[20] = '{4, 20, 8'h04}; vt[21] = '{4, 31, 8'h07};
      vt[22] = '{5, 20, 8'h02}; vt[23] = '{5, 27, 8'h03};
      vt[24] = '{7, 0, 8'h00};  vt[25] = '{7, 12, 8'h04};
`ifdef SALT_PEPPER_EN
      vt[26] = '{0, 4, 8'hFF};  vt[27] = '{0, 9, 8'h00};  vt[28] = '{0, 14, 8'hFF};
`else
      vt[26] = '{0, 4, 8'h04};  vt[27] = '{0, 9, 8'h01};  vt[28] = '{0, 14, 8'h06};
`endif

      rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; en2 = 1'b0; pat2 = 2'd2;
      repeat (3) step();
      chk("rst_vsync", {31'd0, vsync}, 0);
      chk("rst_href",  {31'd0, href}, 0);
      chk("rst_gray",  {24'd0, gray}, 0);
      chk("rst_done",  {31'd0, fdone}, 0);
      chk("rst_fcnt",  {16'd0, fcnt}, 0);
      rst_n = 1'b1;
      repeat (2) step();
      chk("idle_vsync", {31'd0, vsync}, 0);

      // 16x16 checkerboard on the second instance
      en2 = 1'b1;
      n = 0;
      while (vsync2 !== 1'b1 && n < 1000) begin step(); n++; end
      chk("chk_vsync_seen", {31'd0, vsync2}, 1);
      en2 = 1'b0;
      np2 = 0; c = 0;
      while (vsync2 === 1'b1 && c < 2000) begin
         if (href2 === 1'b1) begin
            if (np2 < 256) cpix[np2] = gray2;
            np2++;
         end
         step(); c++;
      end
      chk("chk_npix", np2, 256);
      chk("chk_y0_x0",  {24'd0, cpix[0]},   32'h00);
      chk("chk_y0_x7",  {24'd0, cpix[7]},   32'h00);
      chk("chk_y0_x8",  {24'd0, cpix[8]},   32'hFF);
      chk("chk_y0_x15", {24'd0, cpix[15]},  32'hFF);
      chk("chk_y8_x0",  {24'd0, cpix[128]}, 32'hFF);
      chk("chk_y8_x8",  {24'd0, cpix[136]}, 32'h00);
      chk("chk_y15_x15",{24'd0, cpix[255]}, 32'h00);

      // frame 0: h-ramp with exact blanking timing
      enable = 1'b1;
      wait_vs(n);
      chk("vblank_len", n, 24);
      cap(0, -1, 2'd0, 1'b1, nv, np, hv, fd, fc);
      chk("f0_vsync_len", nv, 48);
      chk("f0_npix", np, 32);
      chk("f0_line_shape", hv, 0);
      chk("f0_done", {31'd0, fd}, 1);
      chk("f0_fcnt", {16'd0, fc}, 1);
      step();
      chk("done_one_cycle", {31'd0, fdone}, 0);

      pattern_sel = 2'd1;
      wait_vs(n);
      cap(1, -1, 2'd1, 1'b1, nv, np, hv, fd, fc);
      chk("f1_fcnt", {16'd0, fc}, 2);

      pattern_sel = 2'd3;
      wait_vs(n);
      cap(2, -1, 2'd3, 1'b1, nv, np, hv, fd, fc);
      chk("f2_fcnt", {16'd0, fc}, 3);
      wait_vs(n);
      cap(3, -1, 2'd3, 1'b1, nv, np, hv, fd, fc);
      chk("f3_fcnt", {16'd0, fc}, 4);

      // pattern change mid-frame must only affect the following frame
      pattern_sel = 2'd0;
      wait_vs(n);
      cap(4, 15, 2'd1, 1'b1, nv, np, hv, fd, fc);
      chk("f4_fcnt", {16'd0, fc}, 5);
      wait_vs(n);
      cap(5, -1, 2'd1, 1'b1, nv, np, hv, fd, fc);
      chk("f5_fcnt", {16'd0, fc}, 6);

      // enable dropped during line 1: frame completes, then idle
      pattern_sel = 2'd0;
      wait_vs(n);
      cap(6, 15, 2'd0, 1'b0, nv, np, hv, fd, fc);
      chk("f6_vsync_len", nv, 48);
      chk("f6_npix", np, 32);
      chk("f6_done", {31'd0, fd}, 1);
      chk("f6_fcnt", {16'd0, fc}, 7);
      bad = 0;
      repeat (40) begin
         step();
         if (vsync !== 1'b0 || href !== 1'b0 || fdone !== 1'b0 || gray !== 8'h00) bad++;
      end
      chk("idle_quiet", bad, 0);
      chk("idle_fcnt", {16'd0, fcnt}, 7);
      enable = 1'b1;
      wait_vs(n);
      chk("reenable_vblank", n, 24);
      cap(7, -1, 2'd0, 1'b1, nv, np, hv, fd, fc);
      chk("f7_fcnt", {16'd0, fc}, 8);

      // reset in the middle of an active line
      wait_vs(n);
      repeat (3) step();
      chk("pre_reset_href", {31'd0, href}, 1);
      rst_n = 1'b0;
      step();
      chk("midrst_vsync", {31'd0, vsync}, 0);
      chk("midrst_href",  {31'd0, href}, 0);
      chk("midrst_gray",  {24'd0, gray}, 0);
      chk("midrst_fcnt",  {16'd0, fcnt}, 0);
      rst_n = 1'b1;
      wait_vs(n);
      chk("restart_vblank", n, 24);

      for (int i = 0; i < NV; i++) begin
         chk($sformatf("pix_f%0d_i%0d", vt[i].frm, vt[i].idx),
             {24'd0, fpix[vt[i].frm][vt[i].idx]}, {24'd0, vt[i].exp});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
